uart_frame_sequencer: RTL and testbench

UART_FRAME_SEQUENCER -- requirements
Module: uart_frame_sequencer

---
 rtl/uart_frame_sequencer_pkg.sv | 29 ++
 rtl/uart_frame_sequencer.sv | 138 +++++++++++++
 tb/tb_uart_frame_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_sequencer_pkg.sv
// Shared state encoding and defaults for the UART frame sequencer.
package uart_frame_sequencer_pkg;

    localparam int         DEF_ADDR_W      = 9;
    localparam logic [7:0] DEF_HEADER_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HDR       = 3'd1,
        FETCH     = 3'd2,
        CAPTURE   = 3'd3,
        ISSUE     = 3'd4,
        WAIT_DONE = 3'd5,
        CSUM      = 3'd6,
        DONE      = 3'd7
    } state_t;

    // Which part of the frame is currently out on the transmitter.
    typedef enum logic [1:0] {
        PH_HDR  = 2'd0,
        PH_PAY  = 2'd1,
        PH_CSUM = 2'd2
    } phase_t;

    function automatic int max_len(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/uart_frame_sequencer.sv
// Streams header, L buffer bytes and their mod-256 sum to a uart_tx, one byte per Tx_Done.
// First byte-valid 3 cycles after an accepted start; each byte holds in ISSUE while the transmitter is busy.
module uart_frame_sequencer
    import uart_frame_sequencer_pkg::*;
#(
    parameter int         ADDR_W      = DEF_ADDR_W,
    parameter logic [7:0] HEADER_BYTE = DEF_HEADER_BYTE
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Start,
    input  logic [ADDR_W:0]   i_Length,
    output logic              o_Rd_En,
    output logic [ADDR_W-1:0] o_Rd_Addr,
    input  logic [7:0]        i_Rd_Data,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done,
    output logic              o_Busy,
    output logic              o_Frame_Done
);

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(max_len(ADDR_W));
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_dv_q, tx_dv_d;
    logic              busy_q, busy_d;
    logic              last_byte;

    // Only evaluated in the payload phase, where len_q is at least 1.
    assign last_byte = ({1'b0, index_q} == (len_q - ONE));

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            phase_q   <= PH_HDR;
            len_q     <= '0;
            index_q   <= '0;
            csum_q    <= '0;
            tx_byte_q <= '0;
            tx_dv_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            len_q     <= len_d;
            index_q   <= index_d;
            csum_q    <= csum_d;
            tx_byte_q <= tx_byte_d;
            tx_dv_q   <= tx_dv_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        len_d     = len_q;
        index_d   = index_q;
        csum_d    = csum_q;
        tx_byte_d = tx_byte_q;
        tx_dv_d   = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (i_Start) begin
                    len_d   = (i_Length > MAX_LEN) ? MAX_LEN : i_Length;
                    index_d = '0;
                    csum_d  = '0;
                    busy_d  = 1'b1;
                    state_d = HDR;
                end
            end
            HDR: begin
                tx_byte_d = HEADER_BYTE;
                phase_d   = PH_HDR;
                state_d   = ISSUE;
            end
            FETCH: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                tx_byte_d = i_Rd_Data;
                csum_d    = csum_q + i_Rd_Data;
                phase_d   = PH_PAY;
                state_d   = ISSUE;
            end
            ISSUE: begin
                if (!i_Tx_Active) begin
                    tx_dv_d = 1'b1;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_Tx_Done) begin
                    case (phase_q)
                        PH_HDR:  state_d = (len_q == '0) ? CSUM : FETCH;
                        PH_PAY: begin
                            if (last_byte) begin
                                state_d = CSUM;
                            end else begin
                                index_d = index_q + ADDR_W'(1);
                                state_d = FETCH;
                            end
                        end
                        PH_CSUM: state_d = DONE;
                        default: state_d = DONE;
                    endcase
                end
            end
            CSUM: begin
                tx_byte_d = csum_q;
                phase_d   = PH_CSUM;
                state_d   = ISSUE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_Rd_En      = (state_q == FETCH);
    assign o_Rd_Addr    = index_q;
    assign o_Tx_DV      = tx_dv_q;
    assign o_Tx_Byte    = tx_byte_q;
    assign o_Busy       = busy_q;
    assign o_Frame_Done = (state_q == DONE);

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Random frames checked against a queue-based frame model, plus literal frames,
// a clamped over-length request and a reset in the middle of the payload.
module tb_uart_frame_sequencer;

    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW:0]   length;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic          tx_active;
    logic          tx_done;
    logic          busy;
    logic          frame_done;

    uart_frame_sequencer #(.ADDR_W(AW), .HEADER_BYTE(8'hA5)) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Start      (start),
        .i_Length     (length),
        .o_Rd_En      (rd_en),
        .o_Rd_Addr    (rd_addr),
        .i_Rd_Data    (rd_data),
        .o_Tx_DV      (tx_dv),
        .o_Tx_Byte    (tx_byte),
        .i_Tx_Active  (tx_active),
        .i_Tx_Done    (tx_done),
        .o_Busy       (busy),
        .o_Frame_Done (frame_done)
    );

    logic [7:0]    mem [DEPTH];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    logic [7:0]    exp_bytes[$];
    logic [7:0]    obs_bytes[$];
    logic [7:0]    lit_q[$];
    int            exp_addr[$];
    int            obs_addr[$];
    bit            frame_open = 0;
    bit            dv_out = 0;
    bit            lat_en = 0;
    int            start_cyc = 0;
    int            first_dv_cyc = 0;
    int            frames_done = 0;
    int            mdl_len;
    logic [7:0]    mdl_sum;
    bit            force_active = 0;
    bit            tx_busy = 0;
    int            tx_cnt = 0;
    bit            rd_pend = 0;
    logic [AW-1:0] pend_addr = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got 'h%0h, expected nothing", name, act);
    endtask

    // Transmitter: busy for 1..4 cycles after each byte-valid, then a done pulse.
    assign tx_active = tx_busy | force_active;
    initial begin
        tx_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            tx_done = 1'b0;
            if (tx_busy) begin
                if (tx_cnt == 0) begin
                    tx_busy = 0;
                    tx_done = 1'b1;
                end else begin
                    tx_cnt--;
                end
            end else if (tx_dv) begin
                tx_busy = 1;
                tx_cnt  = $urandom_range(0, 3);
            end
        end
    end

    // Sample buffer: data valid only in the cycle after the read strobe, noise otherwise.
    initial begin
        rd_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            rd_data   = rd_pend ? mem[pend_addr] : 8'($urandom);
            rd_pend   = rd_en;
            pend_addr = rd_addr;
        end
    end

    // Frame model and per-cycle comparison.
    always @(negedge clk) begin
        if (rst) begin
            exp_bytes.delete();
            exp_addr.delete();
            frame_open = 0;
        end else begin
            if (tx_done) dv_out = 0;
            if (rd_en) begin
                obs_addr.push_back(int'(rd_addr));
                if (exp_addr.size() == 0) fail("rd_unexpected", 32'(rd_addr));
                else chk("rd_addr", 32'(rd_addr), 32'(exp_addr.pop_front()));
            end
            if (tx_dv) begin
                chk("dv_without_done", 32'(dv_out), 32'd0);
                dv_out = 1;
                if (obs_bytes.size() == 0) begin
                    first_dv_cyc = cyc;
                    if (lat_en) chk("start_to_dv_cycles", cyc - start_cyc, 3);
                end
                obs_bytes.push_back(tx_byte);
                if (exp_bytes.size() == 0) fail("dv_unexpected", 32'(tx_byte));
                else chk("tx_byte", 32'(tx_byte), 32'(exp_bytes.pop_front()));
            end
            chk("busy", 32'(busy), 32'(frame_open && (cyc > start_cyc)));
            if (frame_done) begin
                chk("done_in_frame", 32'(frame_open), 32'd1);
                chk("done_bytes_left", exp_bytes.size(), 0);
                chk("done_reads_left", exp_addr.size(), 0);
                frames_done++;
                frame_open = 0;
            end
            if (start && !busy) begin
                mdl_len = (int'(length) > DEPTH) ? DEPTH : int'(length);
                exp_bytes.delete();
                exp_addr.delete();
                obs_bytes.delete();
                obs_addr.delete();
                exp_bytes.push_back(8'hA5);
                mdl_sum = 8'h00;
                for (int i = 0; i < mdl_len; i++) begin
                    exp_bytes.push_back(mem[i]);
                    exp_addr.push_back(i);
                    mdl_sum = mdl_sum + mem[i];
                end
                exp_bytes.push_back(mdl_sum);
                frame_open = 1;
                start_cyc  = cyc;
                lat_en     = !tx_active;
            end
        end
    end

    task automatic check_reset_outputs(input string p);
        chk({p, "_tx_dv"},      32'(tx_dv),      32'd0);
        chk({p, "_rd_en"},      32'(rd_en),      32'd0);
        chk({p, "_busy"},       32'(busy),       32'd0);
        chk({p, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({p, "_tx_byte"},    32'(tx_byte),    32'd0);
        chk({p, "_rd_addr"},    32'(rd_addr),    32'd0);
    endtask

    task automatic check_obs(input string name);
        chk({name, "_len"}, obs_bytes.size(), lit_q.size());
        for (int i = 0; i < lit_q.size() && i < obs_bytes.size(); i++)
            chk(name, 32'(obs_bytes[i]), 32'(lit_q[i]));
    endtask

    task automatic start_frame(input int len, output int fd0);
        for (int i = 0; i < 50 && busy; i++) begin @(posedge clk); #1; end
        fd0    = frames_done;
        length = len[AW:0];
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_frame(input int fd0, input bit noise);
        int n = 0;
        while (frames_done == fd0 && n < 8000) begin
            start = noise && busy && ($urandom_range(0, 5) == 0);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        if (frames_done == fd0) fail("frame_timeout", n);
        repeat (3) begin @(posedge clk); #1; end
        chk("frames_per_start", frames_done - fd0, 1);
    endtask

    task automatic run_frame(input int len, input bit noise);
        int fd0;
        start_frame(len, fd0);
        wait_frame(fd0, noise);
    endtask

    initial begin
        int fd0;
        int n;
        int dv_seen;
        int rel;
        rst    = 1'b1;
        start  = 1'b0;
        length = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        repeat (2) begin @(posedge clk); #1; end
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        run_frame(3, 0);
        lit_q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h06};
        check_obs("frame_l3");
        chk("l3_reads", obs_addr.size(), 3);
        if (obs_addr.size() == 3) chk("l3_last_addr", obs_addr[2], 2);

        run_frame(0, 0);
        lit_q = '{8'hA5, 8'h00};
        check_obs("frame_l0");
        chk("l0_reads", obs_addr.size(), 0);

        mem[0] = 8'hFF; mem[1] = 8'hFF;
        run_frame(2, 1);
        lit_q = '{8'hA5, 8'hFF, 8'hFF, 8'hFE};
        check_obs("frame_ff");

        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
        run_frame(600, 0);
        chk("l600_bytes", obs_bytes.size(), 514);
        if (obs_bytes.size() == 514) chk("l600_csum", 32'(obs_bytes[513]), 32'h00);
        chk("l600_reads", obs_addr.size(), 512);
        if (obs_addr.size() == 512) chk("l600_last_addr", obs_addr[511], 511);

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
            run_frame($urandom_range(0, 40), t[0]);
        end

        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        start_frame(10, fd0);
        n = 0;
        while (obs_bytes.size() < 6 && n < 500) begin @(posedge clk); #1; n++; end
        if (obs_bytes.size() < 6) fail("reset_no_payload5", obs_bytes.size());
        force_active = 1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        chk("midreset_no_done", frames_done, fd0);
        rst = 1'b0;
        start_frame(2, fd0);
        dv_seen = 0;
        repeat (8) begin @(posedge clk); #1; dv_seen += int'(tx_dv); end
        chk("hdr_held_while_active", dv_seen, 0);
        force_active = 0;
        rel = cyc;
        wait_frame(fd0, 0);
        chk("hdr_after_release", first_dv_cyc, rel + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
